// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared widths, responder states and opcodes for the 8-bit RISC SPM
package spm_pkg;

  localparam int SPM_ADDR_W = 8;
  localparam int SPM_DATA_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } resp_state_e;

  // Instruction opcodes, decoded by the control unit
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_RD   = 4'd5;
  localparam logic [3:0] OP_WR   = 4'd6;
  localparam logic [3:0] OP_BR   = 4'd7;
  localparam logic [3:0] OP_BRZ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

endpackage

// File: rtl/spm_ram.sv
// rtl/spm_ram.sv - byte store with one synchronous write port and one asynchronous read port
module spm_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spm_mem_responder.sv
// rtl/spm_mem_responder.sv - SPM memory responder: address register, wait-state FSM, byte store
// Defining SPM_MEM_LOAD_PORT_EN adds the ld_* program preload port, active only during reset.
module spm_mem_responder
  import spm_pkg::*;
#(
  parameter int ADDR_W      = SPM_ADDR_W,
  parameter int DATA_W      = SPM_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              addr_wr_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [DATA_W-1:0] data_in,
`ifdef SPM_MEM_LOAD_PORT_EN
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic [ADDR_W-1:0] addr_q
);

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  resp_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_rd_q, op_wr_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_data_q;
  logic [DATA_W-1:0] dout_q;

  logic              strobe, start, fire, acc_rd, acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data, ram_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign strobe = mem_rd_en | mem_wr_en;
  assign start  = !ZERO_WAIT && (state_q == ST_IDLE) && strobe && !in_rst;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes seen while waiting are ignored; the latched op finishes regardless
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (ZERO_WAIT) begin
      fire     = strobe && !in_rst;
      acc_rd   = mem_rd_en;
      acc_wr   = mem_wr_en;
      acc_addr = addr_q;
      acc_data = data_in;
    end else begin
      fire     = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !in_rst;
      acc_rd   = op_rd_q;
      acc_wr   = op_wr_q;
      acc_addr = lat_addr_q;
      acc_data = lat_data_q;
    end
    mem_ready = fire;
    mem_busy  = (state_q == ST_WAIT) && !in_rst;
    // Async read shows pre-write contents when a write commits in the same cycle
    data_out  = (fire && acc_rd) ? ram_rdata : dout_q;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      addr_q     <= '0;
      op_rd_q    <= 1'b0;
      op_wr_q    <= 1'b0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      dout_q     <= '0;
    end else begin
      if (addr_wr_en) addr_q <= addr_in;
      if (start) begin
        op_rd_q    <= mem_rd_en;
        op_wr_q    <= mem_wr_en;
        lat_addr_q <= addr_q;
        lat_data_q <= data_in;
      end
      dout_q <= data_out;
    end
  end

`ifdef SPM_MEM_LOAD_PORT_EN
  logic preload;
  assign preload   = in_rst && ld_en;
  assign ram_we    = preload || (fire && acc_wr);
  assign ram_waddr = preload ? ld_addr : acc_addr;
  assign ram_wdata = preload ? ld_data : acc_data;
`else
  assign ram_we    = fire && acc_wr;
  assign ram_waddr = acc_addr;
  assign ram_wdata = acc_data;
`endif

  spm_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (in_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (acc_addr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_spm_mem_responder.sv
// tb/tb_spm_mem_responder.sv - randomized bench for zero-wait and 3-wait responders against a byte-store model
module tb_spm_mem_responder;

  localparam int WAIT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic       rst0, awe0, rd0, wr0, rdy0, busy0;
  logic [7:0] ain0, din0, dout0, aq0;
  logic       rst3, awe3, rd3, wr3, rdy3, busy3;
  logic [7:0] ain3, din3, dout3, aq3;
`ifdef SPM_MEM_LOAD_PORT_EN
  logic       ld_en0, ld_en3;
  logic [7:0] ld_addr0, ld_data0, ld_addr3, ld_data3;
`endif

  // Reference model: byte arrays, address register and last visible read byte
  logic [7:0] m0 [256];
  logic [7:0] m3 [256];
  logic [7:0] a0, last0, a3, last3;

  spm_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .in_clk(clk), .in_rst(rst0), .addr_wr_en(awe0), .addr_in(ain0),
    .mem_rd_en(rd0), .mem_wr_en(wr0), .data_in(din0),
`ifdef SPM_MEM_LOAD_PORT_EN
    .ld_en(ld_en0), .ld_addr(ld_addr0), .ld_data(ld_data0),
`endif
    .data_out(dout0), .mem_ready(rdy0), .mem_busy(busy0), .addr_q(aq0)
  );

  spm_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(WAIT3)) u_dut3 (
    .in_clk(clk), .in_rst(rst3), .addr_wr_en(awe3), .addr_in(ain3),
    .mem_rd_en(rd3), .mem_wr_en(wr3), .data_in(din3),
`ifdef SPM_MEM_LOAD_PORT_EN
    .ld_en(ld_en3), .ld_addr(ld_addr3), .ld_data(ld_data3),
`endif
    .data_out(dout3), .mem_ready(rdy3), .mem_busy(busy3), .addr_q(aq3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step0(input logic awe, input logic [7:0] ain, input logic rd, input logic wr,
                       input logic [7:0] din);
    logic [7:0] exp_d;
    awe0 = awe; ain0 = ain; rd0 = rd; wr0 = wr; din0 = din;
    exp_d = rd ? m0[a0] : last0;
    @(negedge clk);
    check_eq("d0_ready", rdy0, rd | wr);
    check_eq("d0_data", dout0, exp_d);
    check_eq("d0_busy", busy0, 0);
    @(posedge clk); #1;
    if (wr) m0[a0] = din;
    last0 = exp_d;
    if (awe) a0 = ain;
    check_eq("d0_addr", aq0, a0);
    awe0 = 0; rd0 = 0; wr0 = 0;
  endtask

  task automatic idle3(input logic awe, input logic [7:0] ain);
    awe3 = awe; ain3 = ain;
    @(negedge clk);
    check_eq("d3_idle_ready", rdy3, 0);
    check_eq("d3_idle_busy", busy3, 0);
    check_eq("d3_idle_data", dout3, last3);
    @(posedge clk); #1;
    if (awe) a3 = ain;
    awe3 = 0;
  endtask

  // One wait-state access: ready exactly WAIT3 cycles after the strobe, busy in between
  task automatic access3(input logic rd, input logic wr, input logic [7:0] din, input bit drop,
                         input int ld_cyc, input logic [7:0] ld_val);
    logic [7:0] acc_a, exp_d;
    acc_a = a3;
    exp_d = rd ? m3[acc_a] : last3;
    rd3 = rd; wr3 = wr; din3 = din;
    for (int c = 0; c <= WAIT3; c++) begin
      awe3 = (c == ld_cyc);
      ain3 = ld_val;
      if (c == 1) begin
        din3 = ~din;
        if (drop) begin rd3 = 0; wr3 = 0; end
        else begin rd3 = 1'($urandom); wr3 = 1'($urandom); end
      end
      @(negedge clk);
      check_eq("d3_ready", rdy3, c == WAIT3);
      check_eq("d3_busy", busy3, c >= 1);
      check_eq("d3_data", dout3, (c == WAIT3) ? exp_d : last3);
      @(posedge clk); #1;
      if (c == ld_cyc) a3 = ld_val;
    end
    awe3 = 0; rd3 = 0; wr3 = 0;
    if (wr) m3[acc_a] = din;
    last3 = exp_d;
    check_eq("d3_addr", aq3, a3);
  endtask

  initial begin
    logic [7:0] x, pre;
    logic       r, w;
    rst0 = 1; awe0 = 0; ain0 = 0; rd0 = 0; wr0 = 0; din0 = 0;
    rst3 = 1; awe3 = 0; ain3 = 0; rd3 = 0; wr3 = 0; din3 = 0;
`ifdef SPM_MEM_LOAD_PORT_EN
    ld_en0 = 0; ld_addr0 = 0; ld_data0 = 0; ld_en3 = 0; ld_addr3 = 0; ld_data3 = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst0 = 0; rst3 = 0;
    a0 = 0; last0 = 0; a3 = 0; last3 = 0;
    @(negedge clk);
    check_eq("rst_addr0", aq0, 0);
    check_eq("rst_data0", dout0, 0);
    check_eq("rst_ready0", rdy0, 0);
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_addr3", aq3, 0);
    check_eq("rst_data3", dout3, 0);
    check_eq("rst_ready3", rdy3, 0);
    check_eq("rst_busy3", busy3, 0);
    @(posedge clk); #1;

    // Fill every byte; each write uses the old address while the next one loads (wraps at 0xFF)
    for (int k = 0; k < 256; k++) step0(1, 8'(k + 1), 0, 1, 8'($urandom));
    for (int k = 0; k < 256; k++) access3(0, 1, 8'($urandom), 0, 0, 8'(k + 1));

    // Zero-wait directed sequences
    step0(1, 8'h10, 0, 0, 0);
    step0(0, 0, 0, 1, 8'hA5);
    step0(0, 0, 1, 0, 0);
    step0(1, 8'h11, 0, 0, 0);
    step0(0, 0, 0, 1, 8'h3C);
    step0(1, 8'h10, 0, 0, 0);
    step0(1, 8'h11, 1, 0, 0);
    step0(0, 0, 1, 0, 0);
    step0(1, 8'h20, 0, 0, 0);
    step0(0, 0, 0, 1, 8'h11);
    step0(0, 0, 1, 1, 8'h77);
    step0(0, 0, 1, 0, 0);
    step0(1, 8'hFF, 0, 1, 8'h5A);
    step0(0, 0, 1, 0, 0);

    for (int k = 0; k < 300; k++)
      step0(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));

    // Reset with both strobes high: no ready, no commit
    x = a0;
    rst0 = 1; rd0 = 1; wr0 = 1; din0 = ~m0[x];
    @(negedge clk);
    check_eq("d0_rst_ready", rdy0, 0);
    @(posedge clk); #1;
    rst0 = 0; rd0 = 0; wr0 = 0;
    a0 = 0; last0 = 0;
    @(negedge clk);
    check_eq("d0_rst_addr", aq0, 0);
    check_eq("d0_rst_data", dout0, 0);
    @(posedge clk); #1;
    step0(1, x, 0, 0, 0);
    step0(0, 0, 1, 0, 0);

`ifdef SPM_MEM_LOAD_PORT_EN
    rst0 = 1; ld_en0 = 1;
    for (int k = 0; k < 4; k++) begin
      ld_addr0 = 8'(k);
      ld_data0 = (k == 0) ? 8'h51 : (k == 1) ? 8'h62 : (k == 2) ? 8'h70 : 8'hFF;
      m0[k] = ld_data0;
      @(posedge clk); #1;
    end
    rst0 = 0; a0 = 0; last0 = 0;
    ld_addr0 = 8'h00; ld_data0 = 8'h00;
    step0(0, 0, 0, 0, 0);
    ld_en0 = 0;
    for (int k = 0; k < 4; k++) step0(1, 8'(k + 1), 1, 0, 0);
`endif

    // Wait-state directed: read, dropped strobe, same-cycle address load, read-before-write
    idle3(1, 8'h10);
    access3(0, 1, 8'hA5, 0, 4, 0);
    access3(1, 0, 0, 0, 4, 0);
    access3(1, 0, 0, 1, 4, 0);
    access3(1, 0, 0, 0, 0, 8'h11);
    idle3(1, 8'h20);
    access3(0, 1, 8'h11, 0, 4, 0);
    access3(1, 1, 8'h77, 0, 2, 8'h20);
    access3(1, 0, 0, 1, 4, 0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(1, 0) == 1) idle3(1, 8'($urandom));
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1;
      access3(r, w, 8'($urandom), 1'($urandom), $urandom_range(4, 0), 8'($urandom));
    end

    // Reset one cycle into a write's wait: aborted, no ready, address cleared
    x = a3;
    pre = m3[x];
    rd3 = 0; wr3 = 1; din3 = ~pre;
    @(negedge clk);
    check_eq("d3_rst_ready_c0", rdy3, 0);
    @(posedge clk); #1;
    rst3 = 1;
    @(negedge clk);
    check_eq("d3_rst_ready_c1", rdy3, 0);
    @(posedge clk); #1;
    rst3 = 0; wr3 = 0;
    a3 = 0; last3 = 0;
    check_eq("d3_rst_addr", aq3, 0);
    for (int c = 0; c < 4; c++) idle3(0, 0);
    idle3(1, x);
    access3(1, 0, 0, 0, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
